mem_arb: RTL and testbench

- Round-robin arbiter that shares the accelerator's single memory port between NUM_REQ requesters, e.g. the pivot-search unit and the row-update unit.
- Sits between the requesters and the memory controller.
- Read and write channels are arbitrated independently.
- Read responses return in order and are routed back to the issuing requester through an outstanding-ID FIFO.

---
 rtl/acc_pkg.sv | 19 +
 rtl/rr_pick.sv | 29 ++
 rtl/mem_arb.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator types plus the memory-arbiter configuration.
package acc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Memory arbiter defaults
    localparam int unsigned ARB_NUM_REQ   = 2;
    localparam int unsigned ARB_MAX_OUTST = 4;

    typedef enum logic {
        W_IDLE,
        W_BUSY
    } wr_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 (mod N) upward and
// returns the first asserted request.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int unsigned cand;

    // Walk the N candidates in rotated priority order; the first hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
// Reads and writes are arbitrated independently; read responses come back in
// order and are steered to their issuer through an outstanding-ID FIFO.
module mem_arb
    import acc_pkg::*;
#(
    parameter int unsigned NUM_REQ   = ARB_NUM_REQ,
    parameter int unsigned MAX_OUTST = ARB_MAX_OUTST
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_REQ-1:0]  req_rden_i,
    input  addr_t [NUM_REQ-1:0] req_raddr_i,
    output logic [NUM_REQ-1:0]  req_rgnt_o,
    output logic [NUM_REQ-1:0]  req_rvalid_o,
    output data_t               req_rdata_o,
    input  logic [NUM_REQ-1:0]  req_wren_i,
    input  addr_t [NUM_REQ-1:0] req_waddr_i,
    input  data_t [NUM_REQ-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]  req_wready_o,
    output logic                mem_rden_o,
    output addr_t               mem_raddr_o,
    input  data_t               mem_rdata_i,
    input  logic                mem_rvalid_i,
    output logic                mem_wren_o,
    output addr_t               mem_waddr_o,
    output data_t               mem_wdata_o,
    input  logic                mem_wready_i,
    output logic                err_o
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    // Pointer increment that wraps at MAX_OUTST.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- read channel ----------------
    logic [ID_W-1:0]  rd_last_q;
    logic             rd_valid;
    logic [ID_W-1:0]  rd_idx;
    logic             rd_gnt, rd_pop, rd_err;
    logic [ID_W-1:0]  fifo_q [MAX_OUTST];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ID_W-1:0]  rd_head;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rd_pick (
        .req   (req_rden_i),
        .last  (rd_last_q),
        .valid (rd_valid),
        .idx   (rd_idx)
    );

    // Full check uses the registered count only, so a same-cycle pop cannot
    // open a path from mem_rvalid_i to mem_rden_o.
    assign rd_gnt  = rd_valid && (cnt_q != CNT_W'(MAX_OUTST)) && !rst_i;
    assign rd_pop  = mem_rvalid_i && (cnt_q != '0) && !rst_i;
    assign rd_err  = mem_rvalid_i && (cnt_q == '0) && !rst_i;
    assign rd_head = fifo_q[rptr_q];

    // Read grant and response routing; everything forced low in reset.
    always_comb begin
        req_rgnt_o   = '0;
        req_rvalid_o = '0;
        req_rdata_o  = '0;
        mem_rden_o   = 1'b0;
        mem_raddr_o  = '0;
        if (!rst_i) begin
            req_rdata_o = mem_rdata_i;
            if (rd_gnt) begin
                mem_rden_o         = 1'b1;
                mem_raddr_o        = req_raddr_i[rd_idx];
                req_rgnt_o[rd_idx] = 1'b1;
            end
            if (rd_pop) begin
                req_rvalid_o[rd_head] = 1'b1;
            end
        end
    end

    // ID storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk_i) begin
        if (rd_gnt) begin
            fifo_q[wptr_q] <= rd_idx;
        end
    end

    // Read pointer, FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_last_q <= ID_W'(NUM_REQ - 1);
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            if (rd_gnt) begin
                wptr_q    <= next_ptr(wptr_q);
                rd_last_q <= rd_idx;
            end
            if (rd_pop) begin
                rptr_q <= next_ptr(rptr_q);
            end
            if (rd_gnt && !rd_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!rd_gnt && rd_pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_e       wr_state_q, wr_state_d;
    logic [ID_W-1:0] wr_own_q, wr_own_d;
    logic [ID_W-1:0] wr_last_q, wr_last_d;
    logic [ID_W-1:0] wr_sel;
    logic            wr_valid;
    logic [ID_W-1:0] wr_idx;
    logic            wr_err;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_wr_pick (
        .req   (req_wren_i),
        .last  (wr_last_q),
        .valid (wr_valid),
        .idx   (wr_idx)
    );

    // Write FSM: grant in W_IDLE, lock onto the owner until accepted or abandoned.
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_own_d     = wr_own_q;
        wr_last_d    = wr_last_q;
        wr_err       = 1'b0;
        wr_sel       = '0;
        mem_wren_o   = 1'b0;
        req_wready_o = '0;
        if (!rst_i) begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (wr_valid) begin
                        mem_wren_o = 1'b1;
                        wr_sel     = wr_idx;
                        if (mem_wready_i) begin
                            req_wready_o[wr_idx] = 1'b1;
                            wr_last_d            = wr_idx;
                        end else begin
                            wr_own_d   = wr_idx;
                            wr_state_d = W_BUSY;
                        end
                    end
                end
                W_BUSY: begin
                    if (!req_wren_i[wr_own_q]) begin
                        // Owner abandoned its write: flag it, keep fairness pointer.
                        wr_err     = 1'b1;
                        wr_state_d = W_IDLE;
                    end else begin
                        mem_wren_o = 1'b1;
                        wr_sel     = wr_own_q;
                        if (mem_wready_i) begin
                            req_wready_o[wr_own_q] = 1'b1;
                            wr_last_d              = wr_own_q;
                            wr_state_d             = W_IDLE;
                        end
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

    assign mem_waddr_o = mem_wren_o ? req_waddr_i[wr_sel] : '0;
    assign mem_wdata_o = mem_wren_o ? req_wdata_i[wr_sel] : '0;

    // Write state, owner and fairness pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            wr_own_q   <= '0;
            wr_last_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            wr_state_q <= wr_state_d;
            wr_own_q   <= wr_own_d;
            wr_last_q  <= wr_last_d;
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (rd_err || wr_err) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations, then a
// randomized phase checked every cycle against a queue-based reference model.
module tb_mem_arb;
    import acc_pkg::*;

    localparam int N         = 2;
    localparam int MAX_OUTST = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    rden, wren;
    addr_t [N-1:0]   raddr, waddr;
    data_t [N-1:0]   wdata;
    logic [N-1:0]    req_rgnt_o, req_rvalid_o, req_wready_o;
    data_t           req_rdata_o, mem_rdata, mem_wdata_o;
    addr_t           mem_raddr_o, mem_waddr_o;
    logic            mem_rden_o, mem_wren_o, mem_rvalid, mem_wready, err_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           m_q[$];
    int           m_rd_last = N - 1;
    int           m_wr_last = N - 1;
    int           m_wr_own  = -1;
    logic         m_err     = 1'b0;
    logic [N-1:0] exp_rgnt  = '0;
    logic [N-1:0] exp_wready = '0;

    always #5 clk = ~clk;

    mem_arb #(
        .NUM_REQ   (N),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_rden_i   (rden),
        .req_raddr_i  (raddr),
        .req_rgnt_o   (req_rgnt_o),
        .req_rvalid_o (req_rvalid_o),
        .req_rdata_o  (req_rdata_o),
        .req_wren_i   (wren),
        .req_waddr_i  (waddr),
        .req_wdata_i  (wdata),
        .req_wready_o (req_wready_o),
        .mem_rden_o   (mem_rden_o),
        .mem_raddr_o  (mem_raddr_o),
        .mem_rdata_i  (mem_rdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_wren_o   (mem_wren_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wready_i (mem_wready),
        .err_o        (err_o)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requester after 'last' in rotated order, or -1.
    function automatic int rr(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // Model: compute expected outputs mid-cycle, compare, then commit state.
    always @(negedge clk) begin
        logic [N-1:0] e_rgnt, e_rvalid, e_wready;
        logic         e_rden, e_wren, e_err;
        addr_t        e_raddr, e_waddr;
        data_t        e_rdata, e_wdata;
        int           rw, ww;
        e_rgnt = '0; e_rvalid = '0; e_wready = '0;
        e_rden = 1'b0; e_wren = 1'b0;
        e_raddr = '0; e_waddr = '0; e_rdata = '0; e_wdata = '0;
        rw = -1; ww = -1;
        e_err = m_err;
        if (rst) begin
            m_q.delete();
            m_rd_last = N - 1;
            m_wr_last = N - 1;
            m_wr_own  = -1;
            m_err     = 1'b0;
            e_err     = 1'b0;
        end else begin
            e_rdata = mem_rdata;
            if (m_q.size() < MAX_OUTST) rw = rr(rden, m_rd_last);
            if (rw >= 0) begin
                e_rden = 1'b1; e_raddr = raddr[rw]; e_rgnt[rw] = 1'b1;
            end
            if (mem_rvalid && m_q.size() > 0) e_rvalid[m_q[0]] = 1'b1;
            if (m_wr_own < 0) ww = rr(wren, m_wr_last);
            else if (wren[m_wr_own]) ww = m_wr_own;
            if (ww >= 0) begin
                e_wren = 1'b1; e_waddr = waddr[ww]; e_wdata = wdata[ww];
                if (mem_wready) e_wready[ww] = 1'b1;
            end
        end
        check("m_rgnt", req_rgnt_o, e_rgnt);
        check("m_rden", mem_rden_o, e_rden);
        check("m_raddr", mem_raddr_o, e_raddr);
        check("m_rvalid", req_rvalid_o, e_rvalid);
        check("m_rdata", req_rdata_o, e_rdata);
        check("m_wren", mem_wren_o, e_wren);
        check("m_waddr", mem_waddr_o, e_waddr);
        check("m_wdata", mem_wdata_o, e_wdata);
        check("m_wready", req_wready_o, e_wready);
        check("m_err", err_o, e_err);
        if (!rst) begin
            if (mem_rvalid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (rw >= 0) begin
                m_q.push_back(rw);
                m_rd_last = rw;
            end
            if (m_wr_own >= 0 && !wren[m_wr_own]) begin
                m_err = 1'b1;
                m_wr_own = -1;
            end else if (ww >= 0) begin
                if (mem_wready) begin
                    m_wr_last = ww;
                    m_wr_own  = -1;
                end else begin
                    m_wr_own = ww;
                end
            end
        end
        exp_rgnt   = e_rgnt;
        exp_wready = e_wready;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rden = 2'b11; wren = '0; raddr = '0; waddr = '0; wdata = '0;
        mem_rdata = 32'h5555_5555; mem_rvalid = 1'b0; mem_wready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rgnt", req_rgnt_o, 2'b00);
        check("rst_rden", mem_rden_o, 1'b0);
        check("rst_rdata", req_rdata_o, 32'h0);
        check("rst_err", err_o, 1'b0);

        // Reads alternate 0,1,0,1 then block at four outstanding
        rst = 1'b0;
        raddr[0] = 16'h0100; raddr[1] = 16'h0200;
        for (int c = 0; c < 4; c++) begin
            mid();
            check("fill_rgnt", req_rgnt_o, (c % 2 == 0) ? 2'b01 : 2'b10);
            check("fill_raddr", mem_raddr_o, (c % 2 == 0) ? 16'h0100 : 16'h0200);
        end
        mid();
        check("full_rgnt", req_rgnt_o, 2'b00);
        check("full_rden", mem_rden_o, 1'b0);

        // Responses route 01,10,01,10; grants resume after the first pop
        nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hA;
        mid();
        check("ret0_rvalid", req_rvalid_o, 2'b01);
        check("ret0_rdata", req_rdata_o, 32'hA);
        check("ret0_rgnt", req_rgnt_o, 2'b00);
        nxt(); mem_rdata = 32'hB;
        mid();
        check("ret1_rvalid", req_rvalid_o, 2'b10);
        check("ret1_rdata", req_rdata_o, 32'hB);
        check("ret1_rgnt", req_rgnt_o, 2'b01);
        nxt(); mem_rdata = 32'hC;
        mid();
        check("ret2_rvalid", req_rvalid_o, 2'b01);
        nxt(); mem_rdata = 32'hD;
        mid();
        check("ret3_rvalid", req_rvalid_o, 2'b10);
        check("ret3_rdata", req_rdata_o, 32'hD);
        nxt(); rden = '0;
        repeat (2) nxt();
        nxt(); mem_rvalid = 1'b0;

        // Write held in W_BUSY, then accepted; next grant rotates to 1
        wren = 2'b11;
        waddr[0] = 16'h0030; wdata[0] = 32'h1111_0000;
        waddr[1] = 16'h0031; wdata[1] = 32'h2222_0000;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("busy_wren", mem_wren_o, 1'b1);
            check("busy_waddr", mem_waddr_o, 16'h0030);
            check("busy_wdata", mem_wdata_o, 32'h1111_0000);
            check("busy_wready", req_wready_o, 2'b00);
        end
        nxt(); mem_wready = 1'b1;
        mid();
        check("acc_wready", req_wready_o, 2'b01);
        mid();
        check("rot_wready", req_wready_o, 2'b10);
        check("rot_waddr", mem_waddr_o, 16'h0031);
        nxt(); wren = '0; mem_wready = 1'b0;

        // Read by 1 and write by 0 in the same cycle
        nxt(); rden = 2'b10; raddr[1] = 16'h0240; wren = 2'b01; mem_wready = 1'b1;
        mid();
        check("par_rden", mem_rden_o, 1'b1);
        check("par_raddr", mem_raddr_o, 16'h0240);
        check("par_rgnt", req_rgnt_o, 2'b10);
        check("par_wren", mem_wren_o, 1'b1);
        check("par_waddr", mem_waddr_o, 16'h0030);
        check("par_wready", req_wready_o, 2'b01);
        nxt(); rden = '0; wren = '0; mem_wready = 1'b0; mem_rvalid = 1'b1;
        nxt(); mem_rvalid = 1'b0;

        // Spurious response with nothing outstanding
        nxt(); mem_rvalid = 1'b1;
        mid();
        check("spur_rvalid", req_rvalid_o, 2'b00);
        check("spur_err_now", err_o, 1'b0);
        nxt(); mem_rvalid = 1'b0;
        mid();
        check("spur_err", err_o, 1'b1);
        repeat (3) nxt();
        check("spur_err_hold", err_o, 1'b1);

        // Asynchronous reset while W_BUSY with two reads in flight
        nxt(); rden = 2'b11; wren = 2'b01; mem_wready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        nxt();
        nxt();
        #1 rst = 1'b1;
        #1;
        check("arst_rden", mem_rden_o, 1'b0);
        check("arst_wren", mem_wren_o, 1'b0);
        check("arst_rgnt", req_rgnt_o, 2'b00);
        check("arst_rdata", req_rdata_o, 32'h0);
        check("arst_err", err_o, 1'b0);
        nxt(); rst = 1'b0; rden = 2'b10; wren = '0; raddr[1] = 16'h02AA;
        mid();
        check("post_rgnt", req_rgnt_o, 2'b10);
        check("post_raddr", mem_raddr_o, 16'h02AA);
        nxt(); rden = '0; mem_rvalid = 1'b1;
        mid();
        check("post_rvalid", req_rvalid_o, 2'b10);
        nxt(); mem_rvalid = 1'b0;
        mid();
        check("post_err", err_o, 1'b0);

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 3000; n++) begin
            nxt();
            for (int i = 0; i < N; i++) begin
                if (!rden[i] || exp_rgnt[i]) begin
                    rden[i]  = ($urandom_range(0, 2) != 0);
                    raddr[i] = addr_t'($urandom);
                end
                if (!wren[i] || exp_wready[i]) begin
                    wren[i]  = ($urandom_range(0, 1) != 0);
                    waddr[i] = addr_t'($urandom);
                    wdata[i] = $urandom;
                end else if ($urandom_range(0, 299) == 0) begin
                    wren[i] = 1'b0;
                end
            end
            mem_wready = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            mem_rvalid = (m_q.size() > 0) ? ($urandom_range(0, 1) != 0)
                                          : ($urandom_range(0, 499) == 0);
        end
        nxt(); rden = '0; wren = '0; mem_rvalid = 1'b0; mem_wready = 1'b0;
        repeat (3) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
